// File: rtl/memory_stage.sv
// Memory stage: issues one data-memory request per aligned load/store, formats
// store lanes and extracts load data; non-memory ops pass straight to writeback.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              execute_memory_v,
  input  logic [WORD_W-1:0] execute_memory_result,
  input  logic [WORD_W-1:0] execute_memory_store_data,
  input  logic [REG_W-1:0]  execute_memory_rd,
  input  logic              execute_memory_rd_w_v,
  input  logic              execute_memory_ld_v,
  input  logic              execute_memory_st_v,
  input  logic [2:0]        execute_memory_size,
  output logic              memory_stall,
  output logic              dmem_req_v,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_resp_v,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              memory_writeback_v,
  output logic [REG_W-1:0]  memory_writeback_rd,
  output logic [WORD_W-1:0] memory_writeback_result,
  output logic              memory_writeback_rd_w_v,
  output logic              memory_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Op fields captured on acceptance
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_sdata;
  logic [REG_W-1:0]  r_rd;
  logic              r_rd_w_v;
  logic              r_ld;
  logic              r_st;
  logic [2:0]        r_size;

  logic              r_wb_v;
  logic              r_wb_rd_w_v;
  logic              r_misaligned;
  logic [REG_W-1:0]  r_wb_rd;
  logic [WORD_W-1:0] r_wb_result;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_in_misaligned;
  logic              w_wb_v;
  logic              w_wb_rd_w_v;
  logic              w_misaligned;
  logic [REG_W-1:0]  w_wb_rd;
  logic [WORD_W-1:0] w_wb_result;
  logic [WORD_W-1:0] w_load_data;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;

  assign memory_stall = (r_state != S_IDLE);
  assign w_accept     = execute_memory_v && !memory_stall;
  assign w_is_mem     = execute_memory_ld_v || execute_memory_st_v;

  always_comb begin
    w_in_misaligned = 1'b0;
    if (w_is_mem) begin
      case (execute_memory_size[1:0])
        2'b00:   w_in_misaligned = 1'b0;
        2'b01:   w_in_misaligned = execute_memory_result[0];
        default: w_in_misaligned = |execute_memory_result[1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_sdata  <= '0;
      r_rd     <= '0;
      r_rd_w_v <= 1'b0;
      r_ld     <= 1'b0;
      r_st     <= 1'b0;
      r_size   <= '0;
    end else if (w_accept) begin
      r_addr   <= execute_memory_result;
      r_sdata  <= execute_memory_store_data;
      r_rd     <= execute_memory_rd;
      r_rd_w_v <= execute_memory_rd_w_v;
      r_ld     <= execute_memory_ld_v;
      r_st     <= execute_memory_st_v;
      r_size   <= execute_memory_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus the writeback that retires on this edge, if any
  always_comb begin
    w_state_nxt  = r_state;
    w_wb_v       = 1'b0;
    w_misaligned = 1'b0;
    w_wb_rd      = r_rd;
    w_wb_rd_w_v  = 1'b0;
    w_wb_result  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            w_wb_v      = 1'b1;
            w_wb_rd     = execute_memory_rd;
            w_wb_rd_w_v = execute_memory_rd_w_v;
            w_wb_result = execute_memory_result;
          end else if (w_in_misaligned) begin
            w_wb_v       = 1'b1;
            w_misaligned = 1'b1;
            w_wb_rd      = execute_memory_rd;
            w_wb_result  = execute_memory_result;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          if (r_ld) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
            w_wb_v      = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (dmem_resp_v) begin
          w_state_nxt = S_IDLE;
          w_wb_v      = 1'b1;
          w_wb_rd_w_v = r_rd_w_v;
          w_wb_result = w_load_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_v       <= 1'b0;
      r_misaligned <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_result  <= '0;
      r_wb_rd_w_v  <= 1'b0;
    end else begin
      r_wb_v       <= w_wb_v;
      r_misaligned <= w_misaligned;
      if (w_wb_v) begin
        r_wb_rd     <= w_wb_rd;
        r_wb_result <= w_wb_result;
        r_wb_rd_w_v <= w_wb_rd_w_v;
      end
    end
  end

  assign dmem_req_v = (r_state == S_REQ);
  assign dmem_we    = dmem_req_v && r_st;
  assign dmem_addr  = {r_addr[WORD_W-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = r_sdata;
    case (r_size[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << r_addr[1:0];
        dmem_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << {r_addr[1], 1'b0};
        dmem_wdata = {2{r_sdata[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = r_sdata;
      end
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_ld_byte = dmem_rdata[7:0];
      2'b01:   w_ld_byte = dmem_rdata[15:8];
      2'b10:   w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    // size[2] marks the unsigned variants
    case (r_size[1:0])
      2'b00:   w_load_data = {{(WORD_W-8){w_ld_byte[7] & ~r_size[2]}}, w_ld_byte};
      2'b01:   w_load_data = {{(WORD_W-16){w_ld_half[15] & ~r_size[2]}}, w_ld_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  assign memory_writeback_v       = r_wb_v;
  assign memory_writeback_rd      = r_wb_rd;
  assign memory_writeback_result  = r_wb_result;
  assign memory_writeback_rd_w_v  = r_wb_rd_w_v;
  assign memory_misaligned        = r_misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: transaction-level reference model checked every
// cycle, plus directed literal scenarios and randomized traffic.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        execute_memory_v;
  logic [31:0] execute_memory_result;
  logic [31:0] execute_memory_store_data;
  logic [4:0]  execute_memory_rd;
  logic        execute_memory_rd_w_v;
  logic        execute_memory_ld_v;
  logic        execute_memory_st_v;
  logic [2:0]  execute_memory_size;
  logic        memory_stall;
  logic        dmem_req_v;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_resp_v;
  logic [31:0] dmem_rdata;
  logic        memory_writeback_v;
  logic [4:0]  memory_writeback_rd;
  logic [31:0] memory_writeback_result;
  logic        memory_writeback_rd_w_v;
  logic        memory_misaligned;

  memory_stage #(.WORD_W(32), .REG_W(5)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .execute_memory_v          (execute_memory_v),
    .execute_memory_result     (execute_memory_result),
    .execute_memory_store_data (execute_memory_store_data),
    .execute_memory_rd         (execute_memory_rd),
    .execute_memory_rd_w_v     (execute_memory_rd_w_v),
    .execute_memory_ld_v       (execute_memory_ld_v),
    .execute_memory_st_v       (execute_memory_st_v),
    .execute_memory_size       (execute_memory_size),
    .memory_stall              (memory_stall),
    .dmem_req_v                (dmem_req_v),
    .dmem_req_ready            (dmem_req_ready),
    .dmem_we                   (dmem_we),
    .dmem_addr                 (dmem_addr),
    .dmem_wdata                (dmem_wdata),
    .dmem_be                   (dmem_be),
    .dmem_resp_v               (dmem_resp_v),
    .dmem_rdata                (dmem_rdata),
    .memory_writeback_v        (memory_writeback_v),
    .memory_writeback_rd       (memory_writeback_rd),
    .memory_writeback_result   (memory_writeback_result),
    .memory_writeback_rd_w_v   (memory_writeback_rd_w_v),
    .memory_misaligned         (memory_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rdw;
    logic        st;
    logic [2:0]  size;
  } op_t;

  op_t         m_op;
  bit          m_pend;     // a memory op is outstanding
  bit          m_granted;  // its request has been handshaken (load awaiting data)
  logic        exp_wb_v, exp_mis, exp_rdw, exp_res_known;
  logic [4:0]  exp_rd;
  logic [31:0] exp_res;

  function automatic int unsigned nbytes(input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 1;
    if (sz[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [2:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] sz);
    int unsigned m;
    m = ((32'd1 << nbytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] sz);
    int unsigned n;
    logic [63:0] lane;
    logic [63:0] acc;
    n    = nbytes(sz);
    lane = {32'd0, d} & ((64'd1 << (8 * n)) - 64'd1);
    acc  = '0;
    for (int unsigned i = 0; i < 4; i += n) acc = acc | (lane << (8 * i));
    return acc[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdat, input logic [31:0] a,
                                           input logic [2:0] sz);
    int unsigned n;
    logic [63:0] mask;
    logic [63:0] lane;
    n    = nbytes(sz);
    mask = (64'd1 << (8 * n)) - 64'd1;
    lane = ({32'd0, rdat} >> (8 * (a % 4))) & mask;
    if (sz[2] == 1'b0 && n < 4 && lane[8 * n - 1]) lane = lane | ~mask;
    return lane[31:0];
  endfunction

  task automatic model_reset();
    m_pend = 0; m_granted = 0; m_op = '0;
    exp_wb_v = 0; exp_mis = 0; exp_rdw = 0; exp_rd = '0; exp_res = '0; exp_res_known = 1;
  endtask

  task automatic m_wb(input logic [31:0] res, input logic [4:0] rd, input logic rdw,
                      input logic mis, input logic known);
    exp_wb_v = 1; exp_mis = mis; exp_res = res; exp_rd = rd; exp_rdw = rdw;
    exp_res_known = known;
  endtask

  // What this clock edge does, from the inputs seen at the edge
  task automatic model_step();
    exp_wb_v = 0;
    exp_mis  = 0;
    if (!m_pend) begin
      if (execute_memory_v) begin
        if (!(execute_memory_ld_v || execute_memory_st_v))
          m_wb(execute_memory_result, execute_memory_rd, execute_memory_rd_w_v, 0, 1);
        else if (ref_misaligned(execute_memory_result, execute_memory_size))
          m_wb(execute_memory_result, execute_memory_rd, 0, 1, 1);
        else begin
          m_pend = 1; m_granted = 0;
          m_op.addr = execute_memory_result;
          m_op.data = execute_memory_store_data;
          m_op.rd   = execute_memory_rd;
          m_op.rdw  = execute_memory_rd_w_v;
          m_op.st   = execute_memory_st_v;
          m_op.size = execute_memory_size;
        end
      end
    end else if (!m_granted) begin
      if (dmem_req_ready) begin
        if (m_op.st) begin
          m_wb(m_op.addr, m_op.rd, 0, 0, 0);
          m_pend = 0;
        end else begin
          m_granted = 1;
        end
      end
    end else if (dmem_resp_v) begin
      m_wb(ref_load(dmem_rdata, m_op.addr, m_op.size), m_op.rd, m_op.rdw, 0, 1);
      m_pend = 0;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", memory_stall, m_pend);
      chk("dmem_req_v", dmem_req_v, m_pend && !m_granted);
      if (m_pend && !m_granted) begin
        chk("dmem_addr", dmem_addr, m_op.addr & ~32'd3);
        chk("dmem_be", dmem_be, ref_be(m_op.addr, m_op.size));
        chk("dmem_we", dmem_we, m_op.st);
        if (m_op.st) chk("dmem_wdata", dmem_wdata, ref_wdata(m_op.data, m_op.size));
      end
      chk("wb_v", memory_writeback_v, exp_wb_v);
      chk("misaligned", memory_misaligned, exp_mis);
      chk("wb_rd", memory_writeback_rd, exp_rd);
      chk("wb_rd_w_v", memory_writeback_rd_w_v, exp_rdw);
      if (exp_res_known) chk("wb_result", memory_writeback_result, exp_res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input logic rdw);
    execute_memory_v          = v;
    execute_memory_ld_v       = ld;
    execute_memory_st_v       = st;
    execute_memory_size       = sz;
    execute_memory_result     = a;
    execute_memory_store_data = d;
    execute_memory_rd         = rd;
    execute_memory_rd_w_v     = rdw;
  endtask

  task automatic lb_case(input logic [2:0] sz, input logic [31:0] exp_val, input string tag);
    set_op(1, 1, 0, sz, 32'h0000_0103, 32'h0, 5'd7, 1);
    dmem_req_ready = 0;
    tick();
    execute_memory_v = 0;
    chk({tag, "_req_v"}, dmem_req_v, 1);
    chk({tag, "_addr"}, dmem_addr, 32'h0000_0100);
    chk({tag, "_be"}, dmem_be, 4'b1000);
    chk({tag, "_we"}, dmem_we, 0);
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0;
    chk({tag, "_wait_req_v"}, dmem_req_v, 0);
    chk({tag, "_wait_stall"}, memory_stall, 1);
    chk({tag, "_wait_wb_v"}, memory_writeback_v, 0);
    dmem_resp_v = 1;
    dmem_rdata  = 32'h80FF_FFFF;
    tick();
    dmem_resp_v = 0;
    chk({tag, "_wb_v"}, memory_writeback_v, 1);
    chk({tag, "_result"}, memory_writeback_result, exp_val);
    chk({tag, "_rd"}, memory_writeback_rd, 5'd7);
    chk({tag, "_rd_w_v"}, memory_writeback_rd_w_v, 1);
    tick();
    chk({tag, "_wb_v_drop"}, memory_writeback_v, 0);
    chk({tag, "_result_hold"}, memory_writeback_result, exp_val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] ld_sizes [5];
  logic [2:0] st_sizes [3];

  initial begin
    int unsigned req_cnt;
    int unsigned wb_cnt;
    ld_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_sizes = '{3'b000, 3'b001, 3'b010};
    set_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    dmem_req_ready = 0;
    dmem_resp_v    = 0;
    dmem_rdata     = '0;
    rst = 1;
    model_reset();
    tick();
    tick();
    rst = 0;
    chk_on = 1;

    // Reset state
    chk("rst_stall", memory_stall, 0);
    chk("rst_req_v", dmem_req_v, 0);
    chk("rst_wb_v", memory_writeback_v, 0);
    chk("rst_mis", memory_misaligned, 0);
    chk("rst_rd", memory_writeback_rd, 0);
    chk("rst_result", memory_writeback_result, 0);
    chk("rst_rd_w_v", memory_writeback_rd_w_v, 0);

    // ALU passthrough
    set_op(1, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1);
    tick();
    execute_memory_v = 0;
    chk("alu_wb_v", memory_writeback_v, 1);
    chk("alu_rd", memory_writeback_rd, 5'd5);
    chk("alu_result", memory_writeback_result, 32'h0000_1234);
    chk("alu_rd_w_v", memory_writeback_rd_w_v, 1);
    chk("alu_stall", memory_stall, 0);
    tick();
    chk("alu_wb_v_drop", memory_writeback_v, 0);

    lb_case(3'b000, 32'hFFFF_FF80, "lb");
    lb_case(3'b100, 32'h0000_0080, "lbu");

    // SH with ready held low for three cycles
    set_op(1, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd9, 1);
    dmem_req_ready = 0;
    req_cnt = 0;
    wb_cnt  = 0;
    tick();
    execute_memory_v = 0;
    for (int i = 0; i < 4; i++) begin
      if (dmem_req_v) req_cnt++;
      if (memory_writeback_v) wb_cnt++;
      chk("sh_stall", memory_stall, 1);
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_we", dmem_we, 1);
      if (i == 3) dmem_req_ready = 1;
      tick();
    end
    dmem_req_ready = 0;
    chk("sh_req_cycles", req_cnt, 4);
    chk("sh_done_req_v", dmem_req_v, 0);
    chk("sh_wb_v", memory_writeback_v, 1);
    chk("sh_rd_w_v", memory_writeback_rd_w_v, 0);
    if (memory_writeback_v) wb_cnt++;
    tick();
    if (memory_writeback_v) wb_cnt++;
    chk("sh_wb_pulses", wb_cnt, 1);

    // Misaligned LW
    set_op(1, 1, 0, 3'b010, 32'h0000_0301, 32'h0, 5'd3, 1);
    tick();
    execute_memory_v = 0;
    chk("lw_mis_req_v", dmem_req_v, 0);
    chk("lw_mis_wb_v", memory_writeback_v, 1);
    chk("lw_mis_flag", memory_misaligned, 1);
    chk("lw_mis_rd_w_v", memory_writeback_rd_w_v, 0);
    chk("lw_mis_result", memory_writeback_result, 32'h0000_0301);
    chk("lw_mis_stall", memory_stall, 0);
    tick();
    chk("lw_mis_flag_drop", memory_misaligned, 0);
    chk("lw_mis_wb_v_drop", memory_writeback_v, 0);

    // Reset while waiting for load data; the late response must be ignored
    set_op(1, 1, 0, 3'b010, 32'h0000_0400, 32'h0, 5'd11, 1);
    dmem_req_ready = 1;
    tick();
    execute_memory_v = 0;
    tick();
    dmem_req_ready = 0;
    chk("rw_wait_stall", memory_stall, 1);
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("rw_async_stall", memory_stall, 0);
    chk("rw_async_req_v", dmem_req_v, 0);
    chk("rw_async_wb_v", memory_writeback_v, 0);
    chk("rw_async_result", memory_writeback_result, 0);
    chk("rw_async_rd", memory_writeback_rd, 0);
    chk("rw_async_rd_w_v", memory_writeback_rd_w_v, 0);
    tick();
    rst = 0;
    dmem_resp_v = 1;
    dmem_rdata  = 32'h1234_5678;
    tick();
    dmem_resp_v = 0;
    chk("rw_late_wb_v", memory_writeback_v, 0);
    chk("rw_late_stall", memory_stall, 0);
    chk("rw_late_req_v", dmem_req_v, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned kind;
      logic [31:0] a;
      logic [2:0]  sz;
      kind = $urandom_range(0, 3);
      a    = $urandom;
      if (kind == 3) sz = st_sizes[$urandom_range(0, 2)];
      else           sz = ld_sizes[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) a = a & ~(nbytes(sz) - 1);
      set_op(($urandom_range(0, 2) != 0), (kind == 1 || kind == 2), (kind == 3), sz, a,
             $urandom, 5'($urandom), 1'($urandom));
      dmem_req_ready = 1'($urandom);
      dmem_resp_v    = 1'($urandom);
      dmem_rdata     = $urandom;
      tick();
    end

    set_op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    dmem_req_ready = 1;
    dmem_resp_v    = 1;
    repeat (4) tick();
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter WORD_W, default 32, data/address width; only 32 is supported.
REQ-002 Parameter REG_W, default 5, register index width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 execute_memory_v  in  1  op valid from execute.
REQ-006 execute_memory_result  in  WORD_W  ALU result / effective address.
REQ-007 execute_memory_store_data  in  WORD_W  store source data.
REQ-008 execute_memory_rd  in  REG_W  destination register.
REQ-009 execute_memory_rd_w_v  in  1  op writes rd.
REQ-010 execute_memory_ld_v / execute_memory_st_v  in  1 each  op is load / store; never both set.
REQ-011 execute_memory_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 memory_stall  out  1  upstream holds; op not accepted.
REQ-013 dmem_req_v  out  1, dmem_req_ready  in  1  request handshake.
REQ-014 dmem_we  out  1, dmem_addr  out  WORD_W (bits[1:0]=0), dmem_wdata  out  WORD_W, dmem_be  out  4.
REQ-015 dmem_resp_v  in  1, dmem_rdata  in  WORD_W  load response.
REQ-016 memory_writeback_v  out  1, memory_writeback_rd  out  REG_W, memory_writeback_result  out  WORD_W, memory_writeback_rd_w_v  out  1.
REQ-017 memory_misaligned  out  1  one-cycle misalignment flag, qualified by memory_writeback_v.

Function
REQ-018 FSM states IDLE, REQ, WAIT; memory_stall = (state != IDLE), combinational from state only.
REQ-019 Op accepted on edge where execute_memory_v=1 and memory_stall=0; all input fields latched on acceptance.
REQ-020 Non-memory op: memory_writeback_v=1 on next edge, result/rd/rd_w_v = latched inputs; state stays IDLE.
REQ-021 Aligned load/store accepted: IDLE->REQ; dmem_req_v=1 throughout REQ, address and controls constant until handshake.
REQ-022 Handshake: edge with dmem_req_v=1 and dmem_req_ready=1.
REQ-023 Store: on handshake REQ->IDLE, memory_writeback_v=1, rd_w_v=0; no response awaited.
REQ-024 Load: on handshake REQ->WAIT; dmem_req_v=0 in WAIT; on edge with dmem_resp_v=1, WAIT->IDLE, memory_writeback_v=1, result = extracted data, rd_w_v = latched rd_w_v.
REQ-025 dmem_resp_v outside WAIT is ignored.
REQ-026 dmem_be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; dmem_we=1 only for stores.
REQ-027 dmem_wdata: B = byte replicated x4, H = halfword replicated x2, W = data unchanged.
REQ-028 Load extract: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-029 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no dmem request, state stays IDLE, next edge memory_writeback_v=1, memory_misaligned=1, rd_w_v=0, result = address.
REQ-030 memory_writeback_v and memory_misaligned are single-cycle pulses per op; other outputs hold last value when v=0.
REQ-031 Back-to-back non-memory ops sustain one op per cycle; minimum load latency accept->v = 3 edges, store = 2 edges.

Reset
REQ-032 rst=1 forces immediately: state IDLE, memory_stall=0, dmem_req_v=0, memory_writeback_v=0, memory_misaligned=0, rd/result/rd_w_v=0.
REQ-033 Reset mid-REQ or mid-WAIT abandons the op; a later dmem_resp_v is ignored.

Verification
REQ-034 ALU op result 0x0000_1234, rd=5 -> next edge v=1, rd=5, result 0x1234, rd_w_v=1, stall=0.
REQ-035 LB addr 0x103, rdata 0x80FF_FFFF, ready and resp after 1 cycle each -> be 4'b1000, dmem_addr 0x100, result 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-036 SH addr 0x202, data 0xABCD, ready held low 3 cycles -> dmem_req_v held 4 cycles, be 4'b1100, wdata 0xABCD_ABCD, stall high throughout, v pulses once with rd_w_v=0.
REQ-037 LW addr 0x301 -> no dmem_req_v, next edge v=1, misaligned=1, rd_w_v=0, result 0x301.
REQ-038 rst asserted in WAIT, then dmem_resp_v=1 after release -> outputs 0 asynchronously, no writeback pulse, state IDLE.
